// File: rtl/fxp_host_seq.sv
// Host-side sequencer for the RV32 fixed-point port: loads one operand into the core,
// runs it until {y1,y2} settles or the cycle budget expires, then hands back the result.
module fxp_host_seq #(
    parameter int MIN_RUN       = 64,
    parameter int STABLE_CYCLES = 16,
    parameter int RUN_MAX       = 4096,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [30:0] op_data,
    output logic        x1,
    output logic [29:0] x2,
    output logic        core_run,
    input  logic        y1,
    input  logic [29:0] y2,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [30:0] res_data,
    output logic        res_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MIN_RUN_C  = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0] STABLE_C   = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] RUN_LAST_C = CNT_W'(RUN_MAX - 1);

    state_t           state_r;
    logic             load_cnt_r;
    logic [CNT_W-1:0] run_cnt_r;
    logic [CNT_W-1:0] stable_cnt_r;
    logic [30:0]      prev_y_r;

    logic [30:0]      y_s;
    logic             match_s;
    logic             settle_s;
    logic             timeout_s;
    logic [CNT_W-1:0] stable_nxt_s;

    // Settle/timeout decisions use the counters as registered at the start of the cycle.
    always_comb begin
        y_s       = {y1, y2};
        match_s   = (y_s == prev_y_r);
        settle_s  = (run_cnt_r >= MIN_RUN_C) && (stable_cnt_r == STABLE_C);
        timeout_s = (run_cnt_r == RUN_LAST_C) && !settle_s;
        if (!match_s) begin
            stable_nxt_s = '0;
        end else if (stable_cnt_r == STABLE_C) begin
            stable_nxt_s = stable_cnt_r;
        end else begin
            stable_nxt_s = stable_cnt_r + CNT_W'(1);
        end
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            op_ready     <= 1'b1;
            x1           <= 1'b0;
            x2           <= 30'd0;
            core_run     <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= 31'd0;
            res_timeout  <= 1'b0;
            load_cnt_r   <= 1'b0;
            run_cnt_r    <= '0;
            stable_cnt_r <= '0;
            prev_y_r     <= 31'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    core_run <= 1'b0;
                    if (op_valid && op_ready) begin
                        x1         <= op_data[30];
                        x2         <= op_data[29:0];
                        load_cnt_r <= 1'b0;
                        op_ready   <= 1'b0;
                        state_r    <= LOAD;
                    end
                end
                // Two cycles with the core held in reset on a stable operand.
                LOAD: begin
                    if (load_cnt_r) begin
                        core_run     <= 1'b1;
                        run_cnt_r    <= '0;
                        stable_cnt_r <= '0;
                        prev_y_r     <= 31'd0;
                        state_r      <= RUN;
                    end else begin
                        load_cnt_r <= 1'b1;
                    end
                end
                RUN: begin
                    run_cnt_r    <= run_cnt_r + CNT_W'(1);
                    prev_y_r     <= y_s;
                    stable_cnt_r <= stable_nxt_s;
                    if (settle_s || timeout_s) begin
                        res_data    <= y_s;
                        res_timeout <= timeout_s;
                        res_valid   <= 1'b1;
                        core_run    <= 1'b0;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    core_run <= 1'b0;
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        op_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    op_ready  <= 1'b1;
                    core_run  <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
